// File: rtl/sound_bus_arbiter_pkg.sv
// Shared types and default addresses for the sound bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sound_bus_arbiter_pkg;

    // Bus cycle phases: pick a requester, align to phi2, hold one phi2 period, ack
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_SEQ = 1'b1
    } req_id_e;

    localparam logic [15:0] DEF_POKEY_BASE = 16'h1820;
    localparam logic [15:0] DEF_LATCH_ADDR = 16'h1840;

    // True when a CPU address targets the 16-byte POKEY window or the output latch
    function automatic logic cpu_addr_hit(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input logic [15:0] latch);
        return ((addr >= base) && (addr <= base + 16'd15)) || (addr == latch);
    endfunction

endpackage

// File: rtl/sound_arb_prio.sv
// CPU-first priority pick with a starvation counter that forces a sequencer grant.
// Latency: combinational grant; counter updates on the grant edge.
// Backpressure: grants only while arb_en (FSM idle); requests simply wait otherwise.
// Sequencer arbitration exists only when SOUND_SEQ_EN is defined.
module sound_arb_prio
    import sound_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    arb_en,
    input  logic    cpu_req,
    input  logic    seq_req,
    output logic    gnt_vld,
    output req_id_e gnt_id
);

`ifdef SOUND_SEQ_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          starved;

    assign starved = (starve_q == CW'(STARVE_MAX));

    // CPU wins a tie unless the sequencer has waited out STARVE_MAX CPU grants
    always_comb begin
        gnt_vld = arb_en && (cpu_req || seq_req);
        gnt_id  = REQ_CPU;
        if (seq_req && (!cpu_req || starved)) begin
            gnt_id = REQ_SEQ;
        end
    end

    // Count CPU grants that bypass a waiting sequencer; saturate, clear when it is served or idle
    always_comb begin
        starve_d = starve_q;
        if (!seq_req) begin
            starve_d = '0;
        end else if (gnt_vld && (gnt_id == REQ_SEQ)) begin
            starve_d = '0;
        end else if (gnt_vld && !starved) begin
            starve_d = starve_q + CW'(1);
        end
    end

    // Starvation counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_seq;
    assign unused_seq = ^{clk, rst, seq_req};

    // Only the CPU can be granted in this build
    always_comb begin
        gnt_vld = arb_en && cpu_req;
        gnt_id  = REQ_CPU;
    end
`endif

endmodule

// File: rtl/sound_bus_arbiter.sv
// Shares the POKEY/latch sound bus between the CPU and the sound sequencer, phi2-aligned.
// Latency: grant to ack is 1-2 phi2 periods plus 2 clk; undecoded CPU addresses ack next clk.
// Backpressure: requesters hold req/payload until their one-clk ack. Sequencer port: SOUND_SEQ_EN.
module sound_bus_arbiter
    import sound_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] POKEY_BASE = DEF_POKEY_BASE,
    parameter logic [15:0] LATCH_ADDR = DEF_LATCH_ADDR,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_3MHz_en,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        seq_req,
    input  logic [3:0]  seq_addr,
    input  logic [7:0]  seq_wdata,
    output logic        seq_ack,
    output logic [15:0] snd_addr,
    output logic [7:0]  snd_wdata,
    output logic        snd_should_read,
    input  logic [7:0]  snd_rdata
);

    state_e      state_q, state_d;
    req_id_e     winner_q, winner_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        gnt_vld;
    req_id_e     gnt_id;
    logic        cpu_hit;

    assign cpu_hit = cpu_addr_hit(cpu_addr, POKEY_BASE, LATCH_ADDR);

    sound_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (state_q == ST_IDLE),
        .cpu_req (cpu_req),
        .seq_req (seq_req),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    // State and latched-access registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            winner_q <= REQ_CPU;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state: undecoded CPU addresses skip the bus cycle and go straight to the ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    if ((gnt_id == REQ_CPU) && !cpu_hit) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: if (clk_3MHz_en) state_d = ST_HOLD;
            ST_HOLD:  if (clk_3MHz_en) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the winner's payload at grant; capture read data as the phi2 period closes
    always_comb begin
        winner_d = winner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        if ((state_q == ST_IDLE) && gnt_vld) begin
            winner_d = gnt_id;
            if (gnt_id == REQ_SEQ) begin
                addr_d  = POKEY_BASE + {12'h000, seq_addr};
                wdata_d = seq_wdata;
                we_d    = 1'b1;
            end else begin
                addr_d  = cpu_addr;
                wdata_d = cpu_wdata;
                we_d    = cpu_we;
                if (!cpu_hit) begin
                    rdata_d = 8'hFF;
                end
            end
        end else if ((state_q == ST_HOLD) && clk_3MHz_en && !we_q) begin
            rdata_d = snd_rdata;
        end
    end

    // Outputs: bus is parked at address 0 except during HOLD; acks pulse in DONE
    always_comb begin
        cpu_ack         = (state_q == ST_DONE) && (winner_q == REQ_CPU);
`ifdef SOUND_SEQ_EN
        seq_ack         = (state_q == ST_DONE) && (winner_q == REQ_SEQ);
`else
        seq_ack         = 1'b0;
`endif
        snd_addr        = '0;
        snd_wdata       = '0;
        snd_should_read = 1'b0;
        if (state_q == ST_HOLD) begin
            snd_addr        = addr_q;
            snd_wdata       = wdata_q;
            snd_should_read = !we_q;
        end
    end

    assign cpu_rdata = rdata_q;

endmodule
